sample_frame_scheduler: RTL and testbench
=========================================

# sample_frame_scheduler

Sensor-clock-domain frame scheduler that paces the channel aggregator. It generates the frame strobe `sensor_valid_all` at a programmable sample period and holds `channel_mask` stable for the whole sweep. It waits for the sys_clk-domain sweep-complete toggle before it issues the next frame, and counts frames dropped because a sweep was still in flight. It sits between the register/config interface and the aggregator, on the sensor side of the CDC boundary.

## Interface
- `NUM_CHANNELS`, 16, width of the channel mask.
- `DIV_WIDTH`, 16, width of the sample-period field.
- `PULSE_CYCLES`, 4, sensor_clk cycles that `sensor_valid_all` stays high; must be ≥ 3 sys_clk periods.
- `TIMEOUT_CYCLES`, 256, sweep-done timeout (only with `SCHED_TIMEOUT_EN`).

Ports:
- `sensor_clk` in 1: clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request, level.
- `sample_period` in DIV_WIDTH: frame period in sensor_clk cycles; sampled at each period reload.
- `mask_cfg` in NUM_CHANNELS: new channel mask.
- `mask_cfg_wr` in 1: single-cycle write strobe for `mask_cfg`.
- `sweep_done_tgl` in 1: asynchronous toggle from the sys_clk domain; each edge means one sweep is complete.
- `sensor_valid_all` out 1: frame strobe to the aggregator, registered.
- `channel_mask` out NUM_CHANNELS: active mask, registered.
- `busy` out 1: high in any state other than IDLE.
- `frame_cnt` out 16: frames issued; wraps at 0xFFFF→0.
- `overrun_cnt` out 8: dropped frames; saturates at 0xFF.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, STROBE, AWAIT_DONE.
- IDLE: the period counter is held at 0. When `enable`=1, load the counter with `eff_period-1` and go to WAIT.
- `eff_period` = max(`sample_period`, PULSE_CYCLES+2). Values 0 and 1 are clamped by this rule.
- The period counter decrements every cycle outside IDLE. A tick occurs when the counter is 0, and the counter then reloads with `eff_period-1`.
- WAIT:
  - On tick → STROBE.
  - If `enable`=0 → IDLE on the next cycle. The tick is ignored.
- STROBE:
  - `sensor_valid_all`=1 for exactly PULSE_CYCLES cycles, then → AWAIT_DONE.
  - On entry cycle, `frame_cnt`+1 and `channel_mask` ← pending mask.
- AWAIT_DONE: on a synchronized done edge:
  - If `enable`=0 → IDLE.
  - Else if tick in the same cycle → STROBE directly. This is not an overrun.
  - Else → WAIT.
- Tick in STROBE, or in AWAIT_DONE without done: the frame is dropped and `overrun_cnt`+1 (saturating). The counter keeps running.
- Done sync:
  - 2-FF synchronizer, then an XOR edge detect against a third flop.
  - A done edge seen in STROBE sets `done_pending`, which AWAIT_DONE consumes on entry.
  - A done edge seen in IDLE or WAIT is discarded.
- Mask:
  - `mask_cfg_wr` writes the pending register.
  - `channel_mask` changes only on STROBE entry, never mid-sweep.
  - A write on the STROBE-entry cycle takes effect on the next frame.
- `enable` dropped during STROBE/AWAIT_DONE: finish the frame, wait for done, then → IDLE.

## Timing
- Reset values:
  - `sensor_valid_all`=0, `channel_mask`=all ones, pending mask=all ones.
  - `busy`=0, `frame_cnt`=0, `overrun_cnt`=0, `timeout_err`=0.
  - FSM=IDLE, sync flops=0.
- `enable` sampled high at cycle 0 → WAIT at cycle 1.
- First `sensor_valid_all` rises at cycle `eff_period`+1. Subsequent rises are exactly `eff_period` apart while no overrun occurs.
- `sweep_done_tgl` edge → detected 3 cycles later.
- Reset mid-operation: all state returns to reset values asynchronously; `sensor_valid_all` drops immediately.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - AWAIT_DONE counts cycles.
  - After TIMEOUT_CYCLES cycles with no done, set `timeout_err`=1 and → WAIT, or → IDLE if `enable`=0.
- `SCHED_TIMEOUT_EN` undefined:
  - AWAIT_DONE waits indefinitely.
  - `timeout_err` is tied to 0 and there is no timeout counter.

## Test plan
- Periodic frames:
  - Stimulus: `sample_period`=40; toggle done 10 cycles after each strobe.
  - Response: strobes 40 cycles apart, each 4 cycles wide; `frame_cnt`=5 after 5 frames; `overrun_cnt`=0.
- Clamp:
  - Stimulus: `sample_period`=0.
  - Response: `eff_period`=6; strobe rises every 6 cycles given prompt done.
- Overrun:
  - Stimulus: `sample_period`=20; done delayed 50 cycles after the strobe.
  - Response: `overrun_cnt`=2 per frame; the next strobe aligns to the tick following done.
- Mask shadowing:
  - Stimulus: write `mask_cfg`=0x00F0 during AWAIT_DONE.
  - Response: `channel_mask` stays 0xFFFF until the next STROBE entry, then becomes 0x00F0.
- Timeout (`SCHED_TIMEOUT_EN`):
  - Stimulus: no done edge.
  - Response: `timeout_err`=1 exactly 256 cycles after AWAIT_DONE entry; the FSM resumes in WAIT.
- Disable and reset:
  - Stimulus: drop `enable` mid-STROBE.
  - Response: the strobe completes its 4 cycles, FSM → IDLE after done.
  - Stimulus: assert `rst_n`=0 mid-STROBE.
  - Response: `sensor_valid_all`=0 and `frame_cnt`=0 immediately.

Source files
------------

// File: rtl/sample_frame_scheduler_if.sv
// Handshake bundle between the register/config side, the scheduler and the
// channel aggregator; the scheduler uses the slave modport.
interface sample_frame_scheduler_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int DIV_WIDTH    = 16
);
  logic                    enable;
  logic [DIV_WIDTH-1:0]    sample_period;
  logic [NUM_CHANNELS-1:0] mask_cfg;
  logic                    mask_cfg_wr;
  logic                    sweep_done_tgl;
  logic                    sensor_valid_all;
  logic [NUM_CHANNELS-1:0] channel_mask;
  logic                    busy;
  logic [15:0]             frame_cnt;
  logic [7:0]              overrun_cnt;
  logic                    timeout_err;

  modport master (
    output enable, sample_period, mask_cfg, mask_cfg_wr, sweep_done_tgl,
    input  sensor_valid_all, channel_mask, busy, frame_cnt, overrun_cnt, timeout_err
  );

  modport slave (
    input  enable, sample_period, mask_cfg, mask_cfg_wr, sweep_done_tgl,
    output sensor_valid_all, channel_mask, busy, frame_cnt, overrun_cnt, timeout_err
  );
endinterface

// File: rtl/sample_frame_scheduler.sv
// Sensor-clock frame pacer for the channel aggregator with shadowed mask and
// overrun counting. Define SCHED_TIMEOUT_EN to add the sweep-done timeout.
module sample_frame_scheduler #(
  parameter int NUM_CHANNELS = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int PULSE_CYCLES = 4
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic                     sensor_clk,
  input logic                     rst_n,
  sample_frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    STROBE     = 2'd2,
    AWAIT_DONE = 2'd3
  } state_t;

  localparam int                   PW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0]        PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(PULSE_CYCLES + 2);
  localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1'b1);

  state_t                  state_r, state_s;
  logic [DIV_WIDTH-1:0]    cnt_r;
  logic [DIV_WIDTH-1:0]    eff_period_s;
  logic [DIV_WIDTH-1:0]    reload_s;
  logic [PW-1:0]           pulse_cnt_r;
  logic                    tick_s;
  logic                    overrun_s;
  logic                    entry_s;
  logic                    done_meta_r, done_sync_r, done_last_r;
  logic                    done_edge_s;
  logic                    done_pending_r;
  logic                    done_s;
  logic [NUM_CHANNELS-1:0] mask_pend_r;
  logic                    valid_r;
  logic [NUM_CHANNELS-1:0] mask_r;
  logic                    busy_r;
  logic [15:0]             frame_cnt_r;
  logic [7:0]              overrun_cnt_r;

  assign eff_period_s = (bus.sample_period < MIN_PERIOD) ? MIN_PERIOD : bus.sample_period;
  assign reload_s     = eff_period_s - ONE;
  assign tick_s       = (state_r != IDLE) && (cnt_r == {DIV_WIDTH{1'b0}});
  assign done_edge_s  = done_sync_r ^ done_last_r;
  // An edge caught while still strobing is parked and honoured on AWAIT_DONE entry.
  assign done_s       = done_edge_s | done_pending_r;
  assign entry_s      = (state_s == STROBE) && (state_r != STROBE);

`ifdef SCHED_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_r;
  logic          timeout_s;
  logic          timeout_r;
`endif

  // Next-state and event decode.
  always_comb begin
    state_s   = state_r;
    overrun_s = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    timeout_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (bus.enable) state_s = WAIT;
        else            state_s = IDLE;
      end
      WAIT: begin
        if (!bus.enable) state_s = IDLE;
        else if (tick_s) state_s = STROBE;
        else             state_s = WAIT;
      end
      STROBE: begin
        overrun_s = tick_s;
        if (pulse_cnt_r == PULSE_LAST) state_s = AWAIT_DONE;
        else                           state_s = STROBE;
      end
      AWAIT_DONE: begin
        if (done_s) begin
          if (!bus.enable) state_s = IDLE;
          else if (tick_s) state_s = STROBE;
          else             state_s = WAIT;
        end else begin
          overrun_s = tick_s;
`ifdef SCHED_TIMEOUT_EN
          if (to_cnt_r == TO_LAST) begin
            timeout_s = 1'b1;
            if (bus.enable) state_s = WAIT;
            else            state_s = IDLE;
          end else begin
            state_s = AWAIT_DONE;
          end
`else
          state_s = AWAIT_DONE;
`endif
        end
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= {DIV_WIDTH{1'b0}};
      pulse_cnt_r    <= {PW{1'b0}};
      done_meta_r    <= 1'b0;
      done_sync_r    <= 1'b0;
      done_last_r    <= 1'b0;
      done_pending_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      done_meta_r <= bus.sweep_done_tgl;
      done_sync_r <= done_meta_r;
      done_last_r <= done_sync_r;
      if (state_r == IDLE) cnt_r <= bus.enable ? reload_s : {DIV_WIDTH{1'b0}};
      else if (tick_s)     cnt_r <= reload_s;
      else                 cnt_r <= cnt_r - ONE;
      if (state_r == STROBE) pulse_cnt_r <= pulse_cnt_r + PW'(1'b1);
      else                   pulse_cnt_r <= {PW{1'b0}};
      if (state_r == STROBE) done_pending_r <= done_pending_r | done_edge_s;
      else                   done_pending_r <= 1'b0;
    end
  end

  // Registered outputs, mask shadow and frame/overrun counters.
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r       <= 1'b0;
      mask_pend_r   <= {NUM_CHANNELS{1'b1}};
      mask_r        <= {NUM_CHANNELS{1'b1}};
      busy_r        <= 1'b0;
      frame_cnt_r   <= 16'd0;
      overrun_cnt_r <= 8'd0;
    end else begin
      valid_r <= (state_s == STROBE);
      busy_r  <= (state_s != IDLE);
      if (bus.mask_cfg_wr) mask_pend_r <= bus.mask_cfg;
      if (entry_s) begin
        mask_r      <= mask_pend_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (overrun_s && (overrun_cnt_r != 8'hFF)) overrun_cnt_r <= overrun_cnt_r + 8'd1;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r  <= {TW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == AWAIT_DONE) && (state_s == AWAIT_DONE)) to_cnt_r <= to_cnt_r + TW'(1'b1);
      else                                                    to_cnt_r <= {TW{1'b0}};
      if (timeout_s) timeout_r <= 1'b1;
    end
  end
  assign bus.timeout_err = timeout_r;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.sensor_valid_all = valid_r;
  assign bus.channel_mask     = mask_r;
  assign bus.busy             = busy_r;
  assign bus.frame_cnt        = frame_cnt_r;
  assign bus.overrun_cnt      = overrun_cnt_r;

endmodule

// File: tb/tb_sample_frame_scheduler.sv
// Directed bench for sample_frame_scheduler: periodic frames, clamp, disable,
// overrun, mask shadowing, async reset and (with SCHED_TIMEOUT_EN) timeout.
module tb_sample_frame_scheduler;

  logic sensor_clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n;
  int   w;

  sample_frame_scheduler_if #(.NUM_CHANNELS(16), .DIV_WIDTH(16)) bus ();

  sample_frame_scheduler dut (
    .sensor_clk (sensor_clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial sensor_clk = 1'b0;
  always #5 sensor_clk = ~sensor_clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge sensor_clk);
  endtask

  // Returns the number of negedges until valid reaches level, or -1 on timeout.
  task automatic wait_valid(input logic level, input int limit, output int cnt);
    int i;
    i   = 0;
    cnt = -1;
    while (cnt < 0 && i < limit) begin
      @(negedge sensor_clk);
      i++;
      if (bus.sensor_valid_all === level) cnt = i;
    end
  endtask

  task automatic toggle_done();
    bus.sweep_done_tgl = ~bus.sweep_done_tgl;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"},   bus.sensor_valid_all, 32'h0);
    check_eq({tag, "_mask"},    bus.channel_mask,     32'hFFFF);
    check_eq({tag, "_busy"},    bus.busy,             32'h0);
    check_eq({tag, "_frames"},  bus.frame_cnt,        32'h0);
    check_eq({tag, "_overrun"}, bus.overrun_cnt,      32'h0);
    check_eq({tag, "_timeout"}, bus.timeout_err,      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.enable         = 1'b0;
    bus.sample_period  = 16'd40;
    bus.mask_cfg       = 16'h0000;
    bus.mask_cfg_wr    = 1'b0;
    bus.sweep_done_tgl = 1'b0;
    cycles(3);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Periodic frames, period 40, done 10 cycles after each rise.
    bus.enable = 1'b1;
    wait_valid(1'b1, 200, n);
    check_eq("p40_first_rise", n, 41);
    for (int f = 1; f <= 5; f++) begin
      wait_valid(1'b0, 20, w);
      check_eq("p40_width", w, 4);
      cycles(6);
      toggle_done();
      if (f < 5) begin
        wait_valid(1'b1, 200, n);
        check_eq("p40_period", 10 + n, 40);
      end
    end
    check_eq("p40_frames", bus.frame_cnt, 5);
    check_eq("p40_overrun", bus.overrun_cnt, 0);
    cycles(10);
    bus.enable = 1'b0;
    cycles(3);
    check_eq("p40_idle_busy", bus.busy, 0);

    // Clamp: period 0 behaves as 6; third frame drops enable mid-strobe.
    bus.sample_period = 16'd0;
    bus.enable        = 1'b1;
    wait_valid(1'b1, 50, n);
    check_eq("clamp_first_rise", n, 7);
    for (int f = 1; f <= 2; f++) begin
      toggle_done();
      wait_valid(1'b0, 20, w);
      check_eq("clamp_width", w, 4);
      wait_valid(1'b1, 50, n);
      check_eq("clamp_period", 4 + n, 6);
    end
    bus.enable = 1'b0;
    wait_valid(1'b0, 20, w);
    check_eq("disable_width", w, 4);
    cycles(10);
    check_eq("disable_busy_waiting", bus.busy, 1);
    check_eq("disable_overrun", bus.overrun_cnt, 2);
    toggle_done();
    cycles(6);
    check_eq("disable_idle_busy", bus.busy, 0);
    check_eq("disable_no_strobe", bus.sensor_valid_all, 0);

    // Fresh start for the overrun and mask checks.
    rst_n = 1'b0;
    cycles(2);
    check_reset_state("rst2");
    rst_n = 1'b1;

    // Overrun: period 20, done 50 cycles after each rise.
    bus.sample_period = 16'd20;
    bus.enable        = 1'b1;
    wait_valid(1'b1, 100, n);
    check_eq("ovr_first_rise", n, 21);
    cycles(50);
    toggle_done();
    wait_valid(1'b1, 100, n);
    check_eq("ovr_period", 50 + n, 60);
    check_eq("ovr_count_1", bus.overrun_cnt, 2);
    cycles(20);
    bus.mask_cfg    = 16'h00F0;
    bus.mask_cfg_wr = 1'b1;
    cycles(1);
    bus.mask_cfg_wr = 1'b0;
    check_eq("mask_held", bus.channel_mask, 16'hFFFF);
    cycles(29);
    toggle_done();
    cycles(9);
    // Write lands on the strobe-entry edge, so it belongs to the next frame.
    bus.mask_cfg    = 16'h0A0A;
    bus.mask_cfg_wr = 1'b1;
    cycles(1);
    bus.mask_cfg_wr = 1'b0;
    check_eq("ovr_rise_aligned", bus.sensor_valid_all, 1);
    check_eq("mask_applied", bus.channel_mask, 16'h00F0);
    check_eq("ovr_count_2", bus.overrun_cnt, 4);
    check_eq("ovr_frames", bus.frame_cnt, 3);
    cycles(50);
    toggle_done();
    wait_valid(1'b1, 100, n);
    check_eq("ovr_period_2", 50 + n, 60);
    check_eq("mask_entry_write", bus.channel_mask, 16'h0A0A);

    // Asynchronous reset in the middle of a strobe.
    cycles(1);
    check_eq("strobe_before_rst", bus.sensor_valid_all, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid_drop", bus.sensor_valid_all, 0);
    check_eq("rst_frames_clear", bus.frame_cnt, 0);
    check_eq("rst_mask", bus.channel_mask, 16'hFFFF);
    cycles(2);
    rst_n = 1'b1;

`ifdef SCHED_TIMEOUT_EN
    bus.sample_period = 16'd20;
    bus.enable        = 1'b1;
    wait_valid(1'b1, 100, n);
    check_eq("to_first_rise", n, 21);
    cycles(259);
    check_eq("to_not_yet", bus.timeout_err, 0);
    cycles(1);
    check_eq("to_set", bus.timeout_err, 1);
    check_eq("to_busy", bus.busy, 1);
    wait_valid(1'b1, 100, n);
    check_eq("to_resume_rise", n, 20);
`else
    cycles(300);
    check_eq("no_timeout", bus.timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
